psd_segment_averager: RTL and testbench
=======================================

Name: psd_segment_averager

Overview:
- Save/Add stage directly downstream of the Blackman–Tukey estimator's PSD output.
- Consumes the sequential |X[k]|^2 bin stream (valid/bin/last) for M = 2^LOG_SEG consecutive frames.
- Accumulates each frame per bin into an internal RAM, then drains the averaged PSD (sum >> LOG_SEG) through a ready/valid output stream.

Parameters:
- W, BT_WL, bin width in bits (unsigned magnitude-squared).
- LOGN, BT_LOGN, log2 of bins per frame; N = 2^LOGN.
- LOG_SEG, BT_LOG_SEG, log2 of segments averaged; M = 2^LOG_SEG.
- ACC_W, W+LOG_SEG, accumulator width; derived, must not be overridden smaller.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart of the averaging set.
- in_valid  in  1  input bin strobe (no backpressure upstream).
- in_bin  in  W  unsigned PSD bin.
- in_last  in  1  marks bin N-1 of a frame.
- out_ready  in  1  downstream accepts out beat.
- out_valid  out  1  averaged bin available.
- out_bin  out  W  averaged bin value.
- out_idx  out  LOGN  bin index of out_bin.
- out_last  out  1  high with out_idx == N-1.
- seg_count  out  LOG_SEG  completed frames in current set.
- busy  out  1  high in DRAIN.
- frame_err  out  1  one-cycle pulse on misaligned frame.
- in_drop  out  1  one-cycle pulse when in_valid is ignored.

Behaviour:
- Reset values: out_valid=0, out_bin=0, out_idx=0, out_last=0, seg_count=0, busy=0, frame_err=0, in_drop=0. State=ACCUM, bin_idx=0. RAM contents are don't-care.
- Two states: ACCUM and DRAIN.
- ACCUM, per in_valid:
  - Segment 0 (seg_count==0): acc[bin_idx] <= in_bin, zero-extended. This overwrite is why no RAM clear is needed.
  - Later segments: acc[bin_idx] <= acc[bin_idx] + in_bin.
  - bin_idx increments by 1.
  - Consecutive in_valid cycles hit distinct addresses. The RMW pipeline must sustain 1 bin/cycle with no lost update.
- Frame end: in_valid with in_last and bin_idx == N-1.
  - If seg_count < M-1: seg_count+1, bin_idx=0.
  - Else: go to DRAIN, busy=1, seg_count=0.
- Misalignment: in_last with bin_idx != N-1, or bin_idx == N-1 without in_last.
  - frame_err pulses for 1 cycle.
  - bin_idx=0 and seg_count=0; the partial set is abandoned.
  - The next frame is treated as segment 0.
- DRAIN:
  - Read acc[0..N-1] in order. out_bin = acc[i][ACC_W-1:LOG_SEG] (truncating divide).
  - First out_valid appears no later than 2 cycles after DRAIN entry.
  - Handshake: a beat transfers when out_valid && out_ready. out_bin, out_idx and out_last stay stable while out_valid && !out_ready.
  - Throughput is 1 beat/cycle while out_ready is held high.
  - After the out_last beat transfers: out_valid=0, busy=0, state=ACCUM.
- in_valid during DRAIN: sample discarded, in_drop pulses that cycle, no RAM write.
- The final accumulation write of a set must land before its RAM read in DRAIN (no read-before-write on bin N-1).
- clear (synchronous) has highest priority:
  - state=ACCUM, bin_idx=0, seg_count=0, out_valid=0, busy=0.
  - A same-cycle in_valid is dropped without an in_drop pulse.
- rst_n asserted mid-DRAIN or mid-frame: all outputs go to reset values immediately; no partial output follows.
- Arithmetic is unsigned with no saturation. ACC_W guarantees M*(2^W-1) fits.

Decomposition:
- bt_config_pkg additions:
  - BT_LOG_SEG constant (default 4).
  - typedef enum logic {PSA_ACCUM, PSA_DRAIN} psa_state_t.
- One sub-module, psd_acc_ram: N x ACC_W simple dual-port RAM with one write port and one read port, 1-cycle registered read.
  - It serves both the ACCUM RMW read and the DRAIN read, muxed by state.

Test Plan (W=16, LOGN=3, LOG_SEG=2: N=8, M=4):
- 4 frames with every bin = 10, 20, 30, 40 respectively, out_ready=1 -> 8 beats, out_bin=25 each, out_idx 0..7, out_last on idx 7, busy falls after the last beat, seg_count back to 0.
- 4 frames bin k = 1,1,1,0 -> acc=3, every out_bin=0 (truncation). Then 4 frames all 0xFFFF -> every out_bin=0xFFFF (acc=0x3FFFC, no wrap).
- out_ready toggled 1,0,0,1,0,1 pattern during drain -> beats stable while stalled, idx sequence 0..7 unbroken, exactly 8 transfers.
- in_last asserted at bin_idx=4 in the second frame -> frame_err 1 pulse, seg_count=0; next 4 clean frames of 8 -> out_bin=8 (earlier data ignored).
- in_valid pulsed 3 times during DRAIN -> in_drop 3 pulses, drained values unchanged. clear asserted mid-DRAIN -> out_valid=0 next cycle, busy=0, new set averages correctly.
- rst_n low mid-frame after 5 bins -> all outputs 0. Then 4 frames of 100 -> out_bin=100 for all 8 bins.

Source files
------------

// File: rtl/psd_segment_averager_pkg.sv
`default_nettype none
// ============================================================================
// psd_segment_averager_pkg : shared constants and state type for the PSD
//                            segment averager.          Rev 1.0
// ============================================================================
package psd_segment_averager_pkg;

  localparam int BT_WL      = 16;
  localparam int BT_LOGN    = 6;
  localparam int BT_LOG_SEG = 4;

  typedef enum logic {
    PSA_ACCUM = 1'b0,
    PSA_DRAIN = 1'b1
  } psa_state_t;

endpackage
`default_nettype wire

// File: rtl/psd_acc_ram.sv
`default_nettype none
// ============================================================================
// psd_acc_ram : simple dual-port accumulator RAM, one write port and one read
//               port with a 1-cycle registered read.        Rev 1.0
// ============================================================================
module psd_acc_ram #(
  parameter int DW = 18,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  // Read data holds while rd_en_i is low, so a stalled consumer keeps its word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/psd_segment_averager.sv
`default_nettype none
// ============================================================================
// psd_segment_averager : accumulates 2^LOG_SEG PSD frames per bin and drains
//                        the truncated mean over a ready/valid stream. Rev 1.0
// ============================================================================
module psd_segment_averager
  import psd_segment_averager_pkg::*;
#(
  parameter int W       = BT_WL,
  parameter int LOGN    = BT_LOGN,
  parameter int LOG_SEG = BT_LOG_SEG,
  parameter int ACC_W   = W + LOG_SEG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [W-1:0]       in_bin,
  input  logic               in_last,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_bin,
  output logic [LOGN-1:0]    out_idx,
  output logic               out_last,
  output logic [LOG_SEG-1:0] seg_count,
  output logic               busy,
  output logic               frame_err,
  output logic               in_drop
);

  psa_state_t         state_q;
  logic [LOGN-1:0]    bin_idx_q;
  logic [LOG_SEG-1:0] seg_q;
  logic               busy_q;
  logic               frame_err_q;
  logic               in_drop_q;

  // Write-back stage of the read-modify-write pipeline.
  logic               p_valid_q;
  logic               p_first_q;
  logic [LOGN-1:0]    p_addr_q;
  logic [W-1:0]       p_bin_q;

  // Drain read pointer and the one outstanding RAM read.
  logic [LOGN-1:0]    rd_ptr_q;
  logic               rd_done_q;
  logic               f_valid_q;
  logic [LOGN-1:0]    f_idx_q;

  logic               out_valid_q;
  logic [W-1:0]       out_bin_q;
  logic [LOGN-1:0]    out_idx_q;
  logic               out_last_q;

  logic               acc_take;
  logic               last_bin;
  logic               misalign;
  logic               advance;
  logic               beat_done;
  logic               drain_issue;
  logic               ram_rd_en;
  logic [LOGN-1:0]    ram_rd_addr;
  logic [ACC_W-1:0]   ram_rd_data;
  logic [ACC_W-1:0]   ram_wr_data;

  assign acc_take    = (state_q == PSA_ACCUM) && in_valid && !clear;
  assign last_bin    = (bin_idx_q == '1);
  assign misalign    = acc_take && (in_last != last_bin);
  assign advance     = !out_valid_q || out_ready;
  assign beat_done   = out_valid_q && out_ready;
  assign drain_issue = (state_q == PSA_DRAIN) && !clear && !rd_done_q &&
                       (!f_valid_q || advance);

  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    ram_wr_data = '0;
    if (state_q == PSA_ACCUM) begin
      ram_rd_en   = acc_take;
      ram_rd_addr = bin_idx_q;
    end else begin
      ram_rd_en   = drain_issue;
      ram_rd_addr = rd_ptr_q;
    end
    // Segment 0 overwrites, so stale RAM contents never need clearing.
    if (p_first_q) begin
      ram_wr_data = ACC_W'(p_bin_q);
    end else begin
      ram_wr_data = ram_rd_data + ACC_W'(p_bin_q);
    end
  end

  psd_acc_ram #(
    .DW (ACC_W),
    .AW (LOGN)
  ) u_acc_ram (
    .clk       (clk),
    .wr_en_i   (p_valid_q),
    .wr_addr_i (p_addr_q),
    .wr_data_i (ram_wr_data),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PSA_ACCUM;
      bin_idx_q   <= '0;
      seg_q       <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      in_drop_q   <= 1'b0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_addr_q    <= '0;
      p_bin_q     <= '0;
      rd_ptr_q    <= '0;
      rd_done_q   <= 1'b0;
      f_valid_q   <= 1'b0;
      f_idx_q     <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      in_drop_q   <= 1'b0;
      p_valid_q   <= acc_take && !misalign;
      p_first_q   <= (seg_q == '0);
      p_addr_q    <= bin_idx_q;
      p_bin_q     <= in_bin;

      if (clear) begin
        state_q     <= PSA_ACCUM;
        bin_idx_q   <= '0;
        seg_q       <= '0;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        f_valid_q   <= 1'b0;
        rd_done_q   <= 1'b0;
        rd_ptr_q    <= '0;
      end else if (state_q == PSA_ACCUM) begin
        if (in_valid) begin
          if (misalign) begin
            frame_err_q <= 1'b1;
            bin_idx_q   <= '0;
            seg_q       <= '0;
          end else if (last_bin) begin
            bin_idx_q <= '0;
            if (seg_q == '1) begin
              state_q   <= PSA_DRAIN;
              busy_q    <= 1'b1;
              seg_q     <= '0;
              rd_ptr_q  <= '0;
              rd_done_q <= 1'b0;
              f_valid_q <= 1'b0;
            end else begin
              seg_q <= seg_q + LOG_SEG'(1);
            end
          end else begin
            bin_idx_q <= bin_idx_q + LOGN'(1);
          end
        end
      end else begin
        in_drop_q <= in_valid;

        if (drain_issue) begin
          rd_ptr_q  <= rd_ptr_q + LOGN'(1);
          rd_done_q <= (rd_ptr_q == '1);
          f_idx_q   <= rd_ptr_q;
          f_valid_q <= 1'b1;
        end else if (advance) begin
          f_valid_q <= 1'b0;
        end

        // Output register reloads only when empty or its beat is leaving.
        if (f_valid_q && advance) begin
          out_valid_q <= 1'b1;
          out_bin_q   <= ram_rd_data[LOG_SEG +: W];
          out_idx_q   <= f_idx_q;
          out_last_q  <= (f_idx_q == '1);
        end else if (beat_done) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          if (out_last_q) begin
            state_q <= PSA_ACCUM;
            busy_q  <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign seg_count = seg_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign in_drop   = in_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_psd_segment_averager.sv
`default_nettype none
// ============================================================================
// tb_psd_segment_averager : directed bench with a per-bin averaging model and
//                           a per-cycle output compare.      Rev 1.0
// ============================================================================
module tb_psd_segment_averager;

  localparam int W = 16;
  localparam int LOGN = 3;
  localparam int LOG_SEG = 2;
  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, in_last, out_ready;
  logic [W-1:0] in_bin;
  logic out_valid, out_last, busy, frame_err, in_drop;
  logic [W-1:0] out_bin;
  logic [LOGN-1:0] out_idx;
  logic [LOG_SEG-1:0] seg_count;

  always #5 clk = ~clk;

  psd_segment_averager #(.W(W), .LOGN(LOGN), .LOG_SEG(LOG_SEG)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bin(in_bin),
    .in_last(in_last), .out_ready(out_ready), .out_valid(out_valid), .out_bin(out_bin),
    .out_idx(out_idx), .out_last(out_last), .seg_count(seg_count), .busy(busy),
    .frame_err(frame_err), .in_drop(in_drop)
  );

  typedef struct { logic [W-1:0] b; logic [LOGN-1:0] idx; } exp_t;
  exp_t exp_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int xfer_cnt = 0;
  int ferr_cnt = 0;
  int drop_cnt = 0;
  logic [W-1:0] last_xfer_bin;
  logic [LOGN-1:0] last_xfer_idx;

  logic [W-1:0] frame_v [N];
  int model_sum [N];
  int model_seg = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: per-bin sums over M clean frames; the mean is the truncated quotient.
  task automatic model_reset();
    for (int k = 0; k < N; k++) model_sum[k] = 0;
    model_seg = 0;
  endtask

  task automatic model_add();
    exp_t e;
    for (int k = 0; k < N; k++) model_sum[k] += int'(frame_v[k]);
    model_seg++;
    if (model_seg == M) begin
      for (int k = 0; k < N; k++) begin
        e.b = W'(model_sum[k] / M);
        e.idx = LOGN'(k);
        exp_q.push_back(e);
      end
      model_reset();
    end
  endtask

  task automatic set_frame(input logic [W-1:0] v);
    for (int k = 0; k < N; k++) frame_v[k] = v;
  endtask

  task automatic send_bins(input int nb, input int last_at);
    for (int k = 0; k < nb; k++) begin
      in_valid = 1'b1;
      in_bin = frame_v[k];
      in_last = (k == last_at);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_bin = '0;
  endtask

  task automatic send_frame();
    send_bins(N, N-1);
    model_add();
  endtask

  task automatic wait_drain(input bit use_pat);
    logic pat [6];
    int n;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      out_ready = use_pat ? pat[n % 6] : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    if (n >= 300) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
    end
  endtask

  // Per-cycle output compare against the model queue.
  logic prev_valid = 0, prev_ready = 0, prev_last = 0;
  logic [W-1:0] prev_bin;
  logic [LOGN-1:0] prev_idx;
  int busy_age = 0;
  bit seen_valid = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
      busy_age = 0;
      seen_valid = 0;
    end else begin
      if (frame_err) ferr_cnt++;
      if (in_drop) drop_cnt++;
      if (!busy) begin
        busy_age = 0;
        seen_valid = 0;
      end else if (!seen_valid) begin
        if (out_valid) begin
          seen_valid = 1;
          chk("first_valid_latency_le2", (busy_age <= 2), 1);
        end else begin
          busy_age++;
        end
      end
      if (prev_valid && !prev_ready) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_bin_stable", out_bin, prev_bin);
        chk("stall_idx_stable", out_idx, prev_idx);
        chk("stall_last_stable", out_last, prev_last);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_idx", out_idx, 32'hFFFF_FFFF);
        end else begin
          chk("out_bin", out_bin, exp_q[0].b);
          chk("out_idx", out_idx, exp_q[0].idx);
          chk("out_last", out_last, (exp_q[0].idx == LOGN'(N-1)));
          if (out_ready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
            last_xfer_bin = out_bin;
            last_xfer_idx = out_idx;
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_bin = out_bin;
      prev_idx = out_idx;
      prev_last = out_last;
    end
  end

  task automatic chk_all_reset(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_bin"}, out_bin, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_seg_count"}, seg_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_in_drop"}, in_drop, 0);
  endtask

  initial begin
    int snap;
    int n;
    rst_n = 0; clear = 0; in_valid = 0; in_last = 0; in_bin = '0; out_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_reset("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Four frames of 10/20/30/40 average to 25.
    set_frame(10); send_frame();
    chk("seg_count_after_1", seg_count, 1);
    set_frame(20); send_frame();
    set_frame(30); send_frame();
    set_frame(40); send_frame();
    chk("busy_in_drain", busy, 1);
    xfer_cnt = 0;
    wait_drain(0);
    chk("t1_transfers", xfer_cnt, 8);
    chk("t1_last_bin", last_xfer_bin, 25);
    chk("t1_last_idx", last_xfer_idx, 7);
    chk("t1_busy_low", busy, 0);
    chk("t1_seg_count", seg_count, 0);

    // Truncation: sum 3 averages to 0.
    set_frame(1); send_frame(); send_frame(); send_frame();
    set_frame(0); send_frame();
    wait_drain(0);
    chk("t2_trunc_bin", last_xfer_bin, 0);

    // Full-scale: 4*0xFFFF must not wrap.
    set_frame(16'hFFFF);
    repeat (M) send_frame();
    wait_drain(0);
    chk("t2_full_scale_bin", last_xfer_bin, 16'hFFFF);

    // Ready toggling during drain.
    for (int k = 0; k < N; k++) frame_v[k] = W'(k * 4);
    repeat (M) send_frame();
    xfer_cnt = 0;
    wait_drain(1);
    chk("t3_transfers", xfer_cnt, 8);
    chk("t3_last_bin", last_xfer_bin, 28);

    // Early in_last at bin 4 of the second frame abandons the set.
    ferr_cnt = 0;
    set_frame(5); send_bins(N, N-1);
    chk("t4_seg_before_err", seg_count, 1);
    send_bins(5, 4);
    @(posedge clk); #1;
    chk("t4_frame_err_pulses", ferr_cnt, 1);
    chk("t4_seg_after_err", seg_count, 0);
    model_reset();
    set_frame(8);
    repeat (M) send_frame();
    wait_drain(0);
    chk("t4_last_bin", last_xfer_bin, 8);
    chk("t4_no_extra_err", ferr_cnt, 1);

    // Input dropped while draining, values unaffected.
    set_frame(4); send_frame();
    set_frame(8); send_frame();
    set_frame(12); send_frame();
    set_frame(16); send_frame();
    out_ready = 0;
    drop_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_bin = 16'h1234;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
    end
    chk("t5_drop_pulses", drop_cnt, 3);
    wait_drain(0);
    chk("t5_last_bin", last_xfer_bin, 10);

    // Clear mid-drain.
    set_frame(50);
    repeat (M) send_frame();
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("t6_drain_started", out_valid, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    snap = drop_cnt;
    clear = 1; in_valid = 1; in_bin = 16'h00AA;
    @(posedge clk); #1;
    clear = 0; in_valid = 0; in_bin = '0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("t6_out_valid_cleared", out_valid, 0);
    chk("t6_busy_cleared", busy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_no_drop_on_clear", drop_cnt, snap);
    set_frame(20); send_frame();
    set_frame(40); send_frame();
    set_frame(60); send_frame();
    set_frame(80); send_frame();
    wait_drain(0);
    chk("t6_new_set_bin", last_xfer_bin, 50);

    // Reset mid-frame.
    set_frame(77);
    send_bins(5, -1);
    rst_n = 0;
    exp_q.delete();
    model_reset();
    #1;
    chk_all_reset("midreset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    set_frame(100);
    repeat (M) send_frame();
    xfer_cnt = 0;
    wait_drain(0);
    chk("t7_transfers", xfer_cnt, 8);
    chk("t7_last_bin", last_xfer_bin, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
